// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake and result bundle between the ID/EX pipeline (master) and the RV32M sequencer (slave).
interface ex_muldiv_ctrl_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_addr_in;
  logic        flush;
  logic        muldiv_stall;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;
  logic [4:0]  fwd_rs_addr;
  logic [31:0] fwd_rs_data;

  modport master (
    output start, funct3, op_a, op_b, rd_addr_in, flush,
    input  muldiv_stall, result_valid, result, rd_addr_out, fwd_rs_addr, fwd_rs_data
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_addr_in, flush,
    output muldiv_stall, result_valid, result, rd_addr_out, fwd_rs_addr, fwd_rs_data
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// RV32M sequencer: 32-step shift-add multiply / restoring divide, 33-cycle latency, stalls EX while busy.
// MULDIV_FAST_MUL_EN: multiplies complete in one cycle from a single-cycle 32x32 product; divides stay iterative.
module ex_muldiv_ctrl (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic        rneg_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;
  logic [4:0]  rd_out_q;

  logic        issue;
  logic        sign_a, sign_b;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;
  logic        fast_mul;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;

  // acc holds {hi, lo} of the product, or {remainder, quotient}; sign is reapplied at the end.
  function automatic logic [31:0] finalize(input logic [63:0] acc, input logic [2:0] f3,
                                           input logic neg, input logic rneg);
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] res;
    p = neg  ? (64'd0 - acc) : acc;
    q = neg  ? (32'd0 - acc[31:0]) : acc[31:0];
    r = rneg ? (32'd0 - acc[63:32]) : acc[63:32];
    case (f3)
      3'b000:                 res = p[31:0];
      3'b001, 3'b010, 3'b011: res = p[63:32];
      3'b100, 3'b101:         res = q;
      default:                res = r;
    endcase
    return res;
  endfunction

  assign issue = (state_q == IDLE) && bus.start && !bus.flush;

  always_comb begin
    sign_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
             (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    sign_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    a_neg  = sign_a && bus.op_a[31];
    b_neg  = sign_b && bus.op_b[31];
    a_abs  = a_neg ? (32'd0 - bus.op_a) : bus.op_a;
    b_abs  = b_neg ? (32'd0 - bus.op_b) : bus.op_b;

    div_zero = bus.funct3[2] && (bus.op_b == 32'd0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
               (bus.op_a == 32'h8000_0000) && (bus.op_b == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;

    if (div_zero)
      special_res = bus.funct3[1] ? bus.op_a : 32'hFFFF_FFFF;
    else
      special_res = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_mul  = !bus.funct3[2];
  assign fast_prod = {32'd0, a_abs} * {32'd0, b_abs};
`else
  assign fast_mul  = 1'b0;
`endif

  // One iteration: multiply adds the multiplicand under lo[0] then shifts right;
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = acc_q[63:31];
    div_diff  = div_shift - {1'b0, b_q};
    if (div_diff[32])
      div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    else
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    acc_d = f3_q[2] ? div_next : mul_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (special || fast_mul) ? DONE : CALC;
      CALC: if (cnt_q == 5'd31) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_comb begin
    bus.muldiv_stall = !bus.flush && (((state_q == IDLE) && bus.start) || (state_q == CALC));
    bus.result_valid = !bus.flush && (state_q == DONE);
    bus.result       = result_q;
    bus.rd_addr_out  = rd_out_q;
    bus.fwd_rs_addr  = bus.result_valid ? rd_out_q : 5'd0;
    bus.fwd_rs_data  = bus.result_valid ? result_q : 32'd0;
  end

  // A flush freezes the datapath in place; only the FSM returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= 64'd0;
      b_q      <= 32'd0;
      f3_q     <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else if (issue) begin
      acc_q  <= {32'd0, a_abs};
      b_q    <= b_abs;
      f3_q   <= bus.funct3;
      rd_q   <= bus.rd_addr_in;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      cnt_q  <= 5'd0;
      if (special) begin
        result_q <= special_res;
        rd_out_q <= bus.rd_addr_in;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (fast_mul) begin
        result_q <= finalize(fast_prod, bus.funct3, a_neg ^ b_neg, a_neg);
        rd_out_q <= bus.rd_addr_in;
      end
`endif
    end else if ((state_q == CALC) && !bus.flush) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        result_q <= finalize(acc_d, f3_q, neg_q, rneg_q);
        rd_out_q <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: arithmetic reference model plus literal expectations.
module tb_ex_muldiv_ctrl;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  int   pulses;

  ex_muldiv_ctrl_if bus ();
  ex_muldiv_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    logic [31:0]        r;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = 32'd0;
    case (f3)
      3'b000: begin p = {32'd0, a} * {32'd0, b};                 r = p[31:0];  end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};     r = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b};           r = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b};                 r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Reference: at most one op in flight, finishing model_lat cycles after issue.
  logic        m_active;
  int          m_t0;
  int          m_lat;
  logic [31:0] m_res;
  logic [4:0]  m_rd;

  always @(negedge clk) begin
    logic e_stall;
    logic e_valid;
    e_stall = 1'b0;
    e_valid = 1'b0;
    if (rst) begin
      m_active = 1'b0;
    end else if (bus.flush) begin
      m_active = 1'b0;
    end else if (m_active && cyc == m_t0 + m_lat) begin
      e_valid  = 1'b1;
      m_active = 1'b0;
    end else if (m_active) begin
      e_stall = 1'b1;
    end else if (bus.start) begin
      e_stall  = 1'b1;
      m_active = 1'b1;
      m_t0     = cyc;
      m_lat    = model_lat(bus.funct3, bus.op_a, bus.op_b);
      m_res    = model_res(bus.funct3, bus.op_a, bus.op_b);
      m_rd     = bus.rd_addr_in;
    end
    chk("stall", {31'd0, bus.muldiv_stall}, {31'd0, e_stall});
    chk("valid", {31'd0, bus.result_valid}, {31'd0, e_valid});
    if (e_valid) begin
      chk("result", bus.result, m_res);
      chk("rd_out", {27'd0, bus.rd_addr_out}, {27'd0, m_rd});
      chk("fwd_addr", {27'd0, bus.fwd_rs_addr}, {27'd0, m_rd});
      chk("fwd_data", bus.fwd_rs_data, m_res);
    end else begin
      chk("fwd_addr_idle", {27'd0, bus.fwd_rs_addr}, 32'd0);
      chk("fwd_data_idle", bus.fwd_rs_data, 32'd0);
    end
    if (rst) begin
      chk("rst_result", bus.result, 32'd0);
      chk("rst_rd_out", {27'd0, bus.rd_addr_out}, 32'd0);
    end
    if (bus.result_valid) pulses++;
  end

  // Issues one op (optionally in the current cycle) and checks literal result, latency and stall span.
  task automatic run_op(input string nm, input logic no_wait, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    int   stall_cnt;
    logic done;
    if (!no_wait) begin
      @(posedge clk);
      #1;
    end
    bus.start      = 1'b1;
    bus.funct3     = f3;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.rd_addr_in = rd;
    done      = 1'b0;
    stall_cnt = 0;
    for (lat = 0; lat < 200; lat++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        done = 1'b1;
        break;
      end
      if (bus.muldiv_stall) stall_cnt++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no result_valid within 200 cycles", nm);
    end else begin
      chk({nm, "_res"}, bus.result, exp_res);
      chk({nm, "_lat"}, lat, exp_lat);
      chk({nm, "_stall_cycles"}, stall_cnt, exp_lat);
      chk({nm, "_fwd_addr"}, {27'd0, bus.fwd_rs_addr}, {27'd0, rd});
      chk({nm, "_fwd_data"}, bus.fwd_rs_data, exp_res);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  initial begin
    int p0;
    tests          = 0;
    fails          = 0;
    cyc            = 0;
    pulses         = 0;
    m_active       = 1'b0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.flush      = 1'b0;
    bus.funct3     = 3'd0;
    bus.op_a       = 32'd0;
    bus.op_b       = 32'd0;
    bus.rd_addr_in = 5'd0;
    #2;
    chk("reset_stall", {31'd0, bus.muldiv_stall}, 32'd0);
    chk("reset_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_rd_out", {27'd0, bus.rd_addr_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op("mul_7_m3",      1'b0, 3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh_min",      1'b1, 3'b001, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, MUL_LAT);
    run_op("mulhu_max",     1'b1, 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu_m1_2",   1'b0, 3'b010, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, MUL_LAT);
    run_op("div_by_zero",   1'b0, 3'b100, 32'd100,        32'd0,         5'd5,  32'hFFFF_FFFF, 1);
    run_op("remu_by_zero",  1'b1, 3'b111, 32'd100,        32'd0,         5'd6,  32'd100,       1);
    run_op("div_ovf",       1'b0, 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1);
    run_op("rem_ovf",       1'b0, 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'd0,         1);
    run_op("rem_m7_2",      1'b0, 3'b110, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFF, 33);
    run_op("div_m7_2",      1'b1, 3'b100, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 33);
    run_op("divu_big_2",    1'b0, 3'b101, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'h7FFF_FFFC, 33);
    run_op("divu_min_max",  1'b0, 3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         33);
    run_op("rem_7_m3",      1'b0, 3'b110, 32'd7,          32'hFFFF_FFFD, 5'd13, 32'd1,         33);

    // Flush on cycle 10 of a DIV; replacement op issues on cycle 11.
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.funct3     = 3'b100;
    bus.op_a       = 32'd5000;
    bus.op_b       = 32'd3;
    bus.rd_addr_in = 5'd14;
    repeat (10) @(posedge clk);
    #1;
    p0 = pulses;
    bus.flush = 1'b1;
    #1;
    chk("flush_stall_low", {31'd0, bus.muldiv_stall}, 32'd0);
    chk("flush_valid_low", {31'd0, bus.result_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    run_op("after_flush_divu", 1'b1, 3'b101, 32'd1000, 32'd7, 5'd15, 32'd142, 33);
    chk("flush_pulse_count", pulses - p0, 32'd1);

    // Reset on cycle 5 of a MUL, then a fresh MUL.
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.funct3     = 3'b000;
    bus.op_a       = 32'd123;
    bus.op_b       = 32'd456;
    bus.rd_addr_in = 5'd16;
    repeat (5) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, bus.muldiv_stall}, 32'd0);
    chk("midrst_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_rd_out", {27'd0, bus.rd_addr_out}, 32'd0);
    chk("midrst_fwd_data", bus.fwd_rs_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("mul_3_4_after_rst", 1'b0, 3'b000, 32'd3, 32'd4, 5'd17, 32'd12, MUL_LAT);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
